// File: rtl/ppfifo_mem_bank_scheduler.sv
// Ping-pong descriptor scheduler for the two-bank PPFIFO-to-memory writer:
// assigns descriptors to banks alternately, tracks completion and raises interrupts.
module ppfifo_mem_bank_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_abort,
  input  logic                  i_desc_stb,
  input  logic [ADDR_WIDTH-1:0] i_desc_base,
  input  logic [SIZE_WIDTH-1:0] i_desc_size,
  output logic                  o_desc_rdy,
  output logic                  o_desc_err,
  output logic                  o_enable,
  output logic [ADDR_WIDTH-1:0] o_memory_0_base,
  output logic [ADDR_WIDTH-1:0] o_memory_1_base,
  output logic [SIZE_WIDTH-1:0] o_memory_0_size,
  output logic [SIZE_WIDTH-1:0] o_memory_1_size,
  output logic                  o_memory_0_new_data,
  output logic                  o_memory_1_new_data,
  input  logic [SIZE_WIDTH-1:0] i_memory_0_count,
  input  logic [SIZE_WIDTH-1:0] i_memory_1_count,
  output logic                  o_done_stb,
  output logic                  o_done_bank,
  output logic [31:0]           o_done_count,
  output logic                  o_int,
  input  logic                  i_int_clear
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]            state_r [2];
  logic [ADDR_WIDTH-1:0] base_r  [2];
  logic [SIZE_WIDTH-1:0] size_r  [2];
  logic [SIZE_WIDTH-1:0] count_s [2];
  logic [1:0]            new_data_r;
  logic                  next_bank_r;
  logic                  desc_err_r;
  logic                  enable_r;
  logic                  done_stb_r;
  logic                  done_bank_r;
  logic [31:0]           done_count_r;
  logic                  int_r;

  logic       rdy_s;
  logic       zero_s;
  logic       accept_s;
  logic [1:0] load_s;
  logic [1:0] rep_s;
  logic [1:0] cand_s;
  logic [1:0] grant_s;
  logic [1:0] live_s;

  assign count_s[0] = i_memory_0_count;
  assign count_s[1] = i_memory_1_count;

  // Accept, report-arbitration and enable qualifiers for the current cycle
  always_comb begin
    // Gating with rst keeps the ready low while reset is held
    rdy_s    = rst && !i_abort && (state_r[next_bank_r] == ST_IDLE);
    zero_s   = (i_desc_size == {SIZE_WIDTH{1'b0}});
    accept_s = i_desc_stb && rdy_s && !zero_s;
    load_s   = {accept_s && next_bank_r, accept_s && !next_bank_r};
    rep_s    = {done_stb_r && done_bank_r, done_stb_r && !done_bank_r};
    cand_s   = 2'b00;
    live_s   = 2'b00;
    for (int b = 0; b < 2; b++) begin
      live_s[b] = (state_r[b] == ST_SETTLE) || (state_r[b] == ST_ACTIVE);
      // A bank is a report candidate when it finishes now or is still waiting in DONE
      cand_s[b] = !i_abort &&
                  (((state_r[b] == ST_ACTIVE) && (count_s[b] == {SIZE_WIDTH{1'b0}})) ||
                   ((state_r[b] == ST_DONE) && !rep_s[b]));
    end
    grant_s = {cand_s[1] && !cand_s[0], cand_s[0]};
  end

  // Per-bank lifecycle: load, settle, wait for drain, wait for report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        state_r[b]    <= ST_IDLE;
        base_r[b]     <= {ADDR_WIDTH{1'b0}};
        size_r[b]     <= {SIZE_WIDTH{1'b0}};
        new_data_r[b] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (i_abort) begin
          if (state_r[b] != ST_IDLE) begin
            state_r[b]    <= ST_IDLE;
            size_r[b]     <= {SIZE_WIDTH{1'b0}};
            new_data_r[b] <= 1'b1;
          end else begin
            new_data_r[b] <= 1'b0;
          end
        end else begin
          new_data_r[b] <= load_s[b];
          case (state_r[b])
            ST_IDLE: begin
              if (load_s[b]) begin
                state_r[b] <= ST_ARM;
                base_r[b]  <= i_desc_base;
                size_r[b]  <= i_desc_size;
              end else begin
                state_r[b] <= ST_IDLE;
              end
            end
            ST_ARM:    state_r[b] <= ST_SETTLE;
            ST_SETTLE: state_r[b] <= ST_ACTIVE;
            ST_ACTIVE: begin
              if (count_s[b] == {SIZE_WIDTH{1'b0}}) begin
                state_r[b] <= ST_DONE;
              end else begin
                state_r[b] <= ST_ACTIVE;
              end
            end
            ST_DONE: begin
              if (rep_s[b]) begin
                state_r[b] <= ST_IDLE;
                size_r[b]  <= {SIZE_WIDTH{1'b0}};
              end else begin
                state_r[b] <= ST_DONE;
              end
            end
            default: begin
              state_r[b] <= ST_IDLE;
              size_r[b]  <= {SIZE_WIDTH{1'b0}};
            end
          endcase
        end
      end
    end
  end

  // Ping-pong pointer, descriptor error, datapath enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_bank_r <= 1'b0;
      desc_err_r  <= 1'b0;
      enable_r    <= 1'b0;
    end else begin
      if (i_abort) begin
        next_bank_r <= 1'b0;
      end else if (accept_s) begin
        next_bank_r <= !next_bank_r;
      end else begin
        next_bank_r <= next_bank_r;
      end
      desc_err_r <= i_desc_stb && rdy_s && zero_s;
      enable_r   <= i_run && !i_abort && (|live_s);
    end
  end

  // Completion report, wrapping counter and sticky interrupt (set beats clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_stb_r   <= 1'b0;
      done_bank_r  <= 1'b0;
      done_count_r <= 32'd0;
      int_r        <= 1'b0;
    end else begin
      done_stb_r <= |grant_s;
      if (|grant_s) begin
        done_bank_r  <= grant_s[1];
        done_count_r <= done_count_r + 32'd1;
        int_r        <= 1'b1;
      end else if (i_int_clear) begin
        int_r <= 1'b0;
      end else begin
        int_r <= int_r;
      end
    end
  end

  assign o_desc_rdy          = rdy_s;
  assign o_desc_err          = desc_err_r;
  assign o_enable            = enable_r;
  assign o_memory_0_base     = base_r[0];
  assign o_memory_1_base     = base_r[1];
  assign o_memory_0_size     = size_r[0];
  assign o_memory_1_size     = size_r[1];
  assign o_memory_0_new_data = new_data_r[0];
  assign o_memory_1_new_data = new_data_r[1];
  assign o_done_stb          = done_stb_r;
  assign o_done_bank         = done_bank_r;
  assign o_done_count        = done_count_r;
  assign o_int               = int_r;

endmodule

// File: tb/tb_ppfifo_mem_bank_scheduler.sv
// Directed bench for ppfifo_mem_bank_scheduler: a per-cycle vector table followed by
// hand-written sequences for run gating, abort and mid-operation reset.
module tb_ppfifo_mem_bank_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run, i_abort, i_desc_stb, i_int_clear;
  logic [31:0] i_desc_base, i_desc_size;
  logic [31:0] i_memory_0_count, i_memory_1_count;
  logic        o_desc_rdy, o_desc_err, o_enable;
  logic [31:0] o_memory_0_base, o_memory_1_base, o_memory_0_size, o_memory_1_size;
  logic        o_memory_0_new_data, o_memory_1_new_data;
  logic        o_done_stb, o_done_bank, o_int;
  logic [31:0] o_done_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ppfifo_mem_bank_scheduler #(.ADDR_WIDTH(32), .SIZE_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_abort(i_abort),
    .i_desc_stb(i_desc_stb), .i_desc_base(i_desc_base), .i_desc_size(i_desc_size),
    .o_desc_rdy(o_desc_rdy), .o_desc_err(o_desc_err), .o_enable(o_enable),
    .o_memory_0_base(o_memory_0_base), .o_memory_1_base(o_memory_1_base),
    .o_memory_0_size(o_memory_0_size), .o_memory_1_size(o_memory_1_size),
    .o_memory_0_new_data(o_memory_0_new_data), .o_memory_1_new_data(o_memory_1_new_data),
    .i_memory_0_count(i_memory_0_count), .i_memory_1_count(i_memory_1_count),
    .o_done_stb(o_done_stb), .o_done_bank(o_done_bank), .o_done_count(o_done_count),
    .o_int(o_int), .i_int_clear(i_int_clear)
  );

  // Inputs for cycle k; rdy is expected during cycle k, everything else after the edge.
  typedef struct {
    logic        run, abort, stb, clr;
    logic [31:0] base, size, cnt0, cnt1;
    logic        rdy, err, en, nd0, nd1, dstb, dbank, intr;
    logic [31:0] size0, size1, base0, base1, dcnt;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  // ctl = {run, abort, stb, clr}; f = {rdy, err, en, nd0, nd1, dstb, dbank, int}
  function automatic vec_t v(input logic [3:0] ctl, input logic [31:0] base, size, c0, c1,
                             input logic [7:0] f, input logic [31:0] s0, s1, b0, b1, dc);
    vec_t r;
    {r.run, r.abort, r.stb, r.clr} = ctl;
    r.base = base; r.size = size; r.cnt0 = c0; r.cnt1 = c1;
    {r.rdy, r.err, r.en, r.nd0, r.nd1, r.dstb, r.dbank, r.intr} = f;
    r.size0 = s0; r.size1 = s1; r.base0 = b0; r.base1 = b1; r.dcnt = dc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic run, abort, stb, clr,
                       input logic [31:0] base, size, c0, c1);
    i_run = run; i_abort = abort; i_desc_stb = stb; i_int_clear = clr;
    i_desc_base = base; i_desc_size = size;
    i_memory_0_count = c0; i_memory_1_count = c1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v(4'b1010, 32'h0,      32'd16, 32'd0,  32'd0, 8'b1001_0000, 32'd16, 32'd0, 32'h0,   32'h0,      32'd0);
    tbl[1]  = v(4'b1000, 32'h0,      32'd0,  32'd16, 32'd0, 8'b1000_0000, 32'd16, 32'd0, 32'h0,   32'h0,      32'd0);
    tbl[2]  = v(4'b1000, 32'h0,      32'd0,  32'd16, 32'd0, 8'b1010_0000, 32'd16, 32'd0, 32'h0,   32'h0,      32'd0);
    tbl[3]  = v(4'b1000, 32'h0,      32'd0,  32'd8,  32'd0, 8'b1010_0000, 32'd16, 32'd0, 32'h0,   32'h0,      32'd0);
    tbl[4]  = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b1010_0101, 32'd16, 32'd0, 32'h0,   32'h0,      32'd1);
    tbl[5]  = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b1000_0001, 32'd0,  32'd0, 32'h0,   32'h0,      32'd1);
    tbl[6]  = v(4'b1010, 32'h100,    32'd0,  32'd0,  32'd0, 8'b1100_0001, 32'd0,  32'd0, 32'h0,   32'h0,      32'd1);
    tbl[7]  = v(4'b1010, 32'h300,    32'd4,  32'd0,  32'd0, 8'b1000_1001, 32'd0,  32'd4, 32'h0,   32'h300,    32'd1);
    tbl[8]  = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd4, 8'b1000_0001, 32'd0,  32'd4, 32'h0,   32'h300,    32'd1);
    tbl[9]  = v(4'b1001, 32'h0,      32'd0,  32'd0,  32'd4, 8'b1010_0000, 32'd0,  32'd4, 32'h0,   32'h300,    32'd1);
    tbl[10] = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b1010_0111, 32'd0,  32'd4, 32'h0,   32'h300,    32'd2);
    tbl[11] = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b1000_0001, 32'd0,  32'd0, 32'h0,   32'h300,    32'd2);
    tbl[12] = v(4'b1010, 32'h0,      32'd8,  32'd0,  32'd0, 8'b1001_0001, 32'd8,  32'd0, 32'h0,   32'h300,    32'd2);
    tbl[13] = v(4'b1010, 32'h200000, 32'd8,  32'd8,  32'd0, 8'b1000_1001, 32'd8,  32'd8, 32'h0,   32'h200000, 32'd2);
    tbl[14] = v(4'b1010, 32'h400,    32'd5,  32'd8,  32'd8, 8'b0010_0001, 32'd8,  32'd8, 32'h0,   32'h200000, 32'd2);
    tbl[15] = v(4'b1010, 32'h400,    32'd5,  32'd8,  32'd8, 8'b0010_0001, 32'd8,  32'd8, 32'h0,   32'h200000, 32'd2);
    tbl[16] = v(4'b1010, 32'h400,    32'd5,  32'd0,  32'd8, 8'b0010_0101, 32'd8,  32'd8, 32'h0,   32'h200000, 32'd3);
    tbl[17] = v(4'b1010, 32'h400,    32'd5,  32'd0,  32'd8, 8'b0010_0001, 32'd0,  32'd8, 32'h0,   32'h200000, 32'd3);
    tbl[18] = v(4'b1010, 32'h400,    32'd5,  32'd0,  32'd8, 8'b1011_0001, 32'd5,  32'd8, 32'h400, 32'h200000, 32'd3);
    tbl[19] = v(4'b1000, 32'h0,      32'd0,  32'd5,  32'd8, 8'b0010_0001, 32'd5,  32'd8, 32'h400, 32'h200000, 32'd3);
    tbl[20] = v(4'b1001, 32'h0,      32'd0,  32'd5,  32'd8, 8'b0010_0000, 32'd5,  32'd8, 32'h400, 32'h200000, 32'd3);
    tbl[21] = v(4'b1001, 32'h0,      32'd0,  32'd0,  32'd0, 8'b0010_0101, 32'd5,  32'd8, 32'h400, 32'h200000, 32'd4);
    tbl[22] = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b0000_0111, 32'd0,  32'd8, 32'h400, 32'h200000, 32'd5);
    tbl[23] = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b0000_0001, 32'd0,  32'd0, 32'h400, 32'h200000, 32'd5);
    tbl[24] = v(4'b1000, 32'h0,      32'd0,  32'd0,  32'd0, 8'b1000_0001, 32'd0,  32'd0, 32'h400, 32'h200000, 32'd5);

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
    repeat (3) step();
    chk("rst.rdy", o_desc_rdy, 1'b0);
    chk("rst.err", o_desc_err, 1'b0);
    chk("rst.en", o_enable, 1'b0);
    chk("rst.size0", o_memory_0_size, 32'd0);
    chk("rst.size1", o_memory_1_size, 32'd0);
    chk("rst.base0", o_memory_0_base, 32'd0);
    chk("rst.base1", o_memory_1_base, 32'd0);
    chk("rst.nd", {o_memory_1_new_data, o_memory_0_new_data}, 2'b00);
    chk("rst.done", {o_done_stb, o_done_bank, o_int}, 3'b000);
    chk("rst.dcnt", o_done_count, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].run, tbl[i].abort, tbl[i].stb, tbl[i].clr,
            tbl[i].base, tbl[i].size, tbl[i].cnt0, tbl[i].cnt1);
      #1;
      chk($sformatf("v%0d.rdy", i), o_desc_rdy, tbl[i].rdy);
      step();
      chk($sformatf("v%0d.err", i), o_desc_err, tbl[i].err);
      chk($sformatf("v%0d.en", i), o_enable, tbl[i].en);
      chk($sformatf("v%0d.nd0", i), o_memory_0_new_data, tbl[i].nd0);
      chk($sformatf("v%0d.nd1", i), o_memory_1_new_data, tbl[i].nd1);
      chk($sformatf("v%0d.size0", i), o_memory_0_size, tbl[i].size0);
      chk($sformatf("v%0d.size1", i), o_memory_1_size, tbl[i].size1);
      chk($sformatf("v%0d.base0", i), o_memory_0_base, tbl[i].base0);
      chk($sformatf("v%0d.base1", i), o_memory_1_base, tbl[i].base1);
      chk($sformatf("v%0d.dstb", i), o_done_stb, tbl[i].dstb);
      if (tbl[i].dstb) chk($sformatf("v%0d.dbank", i), o_done_bank, tbl[i].dbank);
      chk($sformatf("v%0d.dcnt", i), o_done_count, tbl[i].dcnt);
      chk($sformatf("v%0d.int", i), o_int, tbl[i].intr);
    end

    // Run gating and abort with both banks active; next bank pointer is 1 here
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd10, 32'd0, 32'd0);
    step();
    chk("a.arm1.nd1", o_memory_1_new_data, 1'b1);
    chk("a.arm1.size1", o_memory_1_size, 32'd10);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'd12, 32'd0, 32'd10);
    step();
    chk("a.arm0.nd0", o_memory_0_new_data, 1'b1);
    chk("a.arm0.base0", o_memory_0_base, 32'h2000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd12, 32'd10);
    step();
    step();
    chk("a.both.en", o_enable, 1'b1);
    i_run = 1'b0;
    step();
    chk("a.pause.en", o_enable, 1'b0);
    chk("a.pause.size0", o_memory_0_size, 32'd12);
    chk("a.pause.size1", o_memory_1_size, 32'd10);
    step();
    chk("a.pause2.en", o_enable, 1'b0);
    chk("a.pause2.dstb", o_done_stb, 1'b0);
    i_run = 1'b1;
    step();
    chk("a.resume.en", o_enable, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3000, 32'd3, 32'd12, 32'd10);
    #1;
    chk("a.abort.rdy", o_desc_rdy, 1'b0);
    step();
    chk("a.abort.sizes", {o_memory_1_size, o_memory_0_size}, 64'd0);
    chk("a.abort.nd", {o_memory_1_new_data, o_memory_0_new_data}, 2'b11);
    chk("a.abort.en", o_enable, 1'b0);
    chk("a.abort.dstb", o_done_stb, 1'b0);
    chk("a.abort.dcnt", o_done_count, 32'd5);
    chk("a.abort.int", o_int, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
    step();
    chk("a.post.nd", {o_memory_1_new_data, o_memory_0_new_data}, 2'b00);
    chk("a.post.base0", o_memory_0_base, 32'h2000);
    chk("a.post.dstb", o_done_stb, 1'b0);
    step();
    chk("a.post2.dstb", o_done_stb, 1'b0);
    chk("a.post2.dcnt", o_done_count, 32'd5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h4000, 32'd2, 32'd0, 32'd0);
    #1;
    chk("a.repush.rdy", o_desc_rdy, 1'b1);
    step();
    chk("a.repush.nd", {o_memory_1_new_data, o_memory_0_new_data}, 2'b01);
    chk("a.repush.size0", o_memory_0_size, 32'd2);
    chk("a.repush.base0", o_memory_0_base, 32'h4000);

    // Reset asserted while a completion is being reported
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd2, 32'd0);
    step();
    step();
    i_memory_0_count = 32'd0;
    step();
    chk("b.done.dstb", o_done_stb, 1'b1);
    chk("b.done.dbank", o_done_bank, 1'b0);
    chk("b.done.dcnt", o_done_count, 32'd6);
    #2 rst = 1'b0;
    #1;
    chk("b.rst.dstb", o_done_stb, 1'b0);
    chk("b.rst.dcnt", o_done_count, 32'd0);
    chk("b.rst.int", o_int, 1'b0);
    chk("b.rst.size0", o_memory_0_size, 32'd0);
    chk("b.rst.base0", o_memory_0_base, 32'd0);
    chk("b.rst.rdy", o_desc_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("b.rel.dstb", o_done_stb, 1'b0);
    chk("b.rel.dcnt", o_done_count, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd7, 32'd0, 32'd0);
    #1;
    chk("b.push.rdy", o_desc_rdy, 1'b1);
    step();
    chk("b.push.nd0", o_memory_0_new_data, 1'b1);
    chk("b.push.size0", o_memory_0_size, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ppfifo_mem_bank_scheduler.md
# ppfifo_mem_bank_scheduler

Sequences the two-bank ping-pong memory writer: accepts buffer descriptors (base, size in 32-bit words) from a host register interface, alternately loads them into memory bank 0 and bank 1 of the PPFIFO-to-memory datapath, and detects when each bank has been fully written. It reports each completion with a bank id, a completion counter and a sticky interrupt. It sits between the host control registers and the datapath's per-bank base/size/new_data/count ports, and gates the datapath enable.

## Interface
- ADDR_WIDTH, 32, width of descriptor base
- SIZE_WIDTH, 32, width of descriptor size and of the datapath bank counts
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_run  in  1  host run enable
- i_abort  in  1  one-cycle pulse; cancel all banks
- i_desc_stb  in  1  descriptor push strobe
- i_desc_base  in  ADDR_WIDTH  descriptor base address
- i_desc_size  in  SIZE_WIDTH  descriptor length in words
- o_desc_rdy  out  1  scheduler can accept a descriptor this cycle
- o_desc_err  out  1  one-cycle pulse; zero-size descriptor rejected
- o_enable  out  1  datapath enable
- o_memory_0_base / o_memory_1_base  out  ADDR_WIDTH  bank base to datapath
- o_memory_0_size / o_memory_1_size  out  SIZE_WIDTH  bank size to datapath
- o_memory_0_new_data / o_memory_1_new_data  out  1  one-cycle pulse; datapath resets that bank's pointer
- i_memory_0_count / i_memory_1_count  in  SIZE_WIDTH  words remaining per bank
- o_done_stb  out  1  one-cycle completion pulse
- o_done_bank  out  1  bank id of the completion
- o_done_count  out  32  total completions since reset (wraps)
- o_int  out  1  sticky completion interrupt
- i_int_clear  in  1  clears o_int

## Operation
- Each bank has its own FSM: IDLE -> ARM -> SETTLE -> ACTIVE -> DONE -> IDLE.
  - IDLE: size output is 0.
  - ARM: on descriptor accept, latch base and size, and pulse new_data for exactly this cycle.
  - SETTLE: one cycle, to let the datapath pointer reset propagate into its count.
  - ACTIVE: wait for i_memory_N_count == 0, then go to DONE.
  - DONE: hold until reported on o_done_stb, then drive size to 0 and return to IDLE.
- Descriptor accept:
  - Condition: i_desc_stb && o_desc_rdy.
  - o_desc_rdy = (state[r_next_bank] == IDLE) && !i_abort.
  - r_next_bank resets to 0 and toggles on every accept, giving strict ping-pong assignment.
- Zero size: i_desc_stb with o_desc_rdy high and i_desc_size == 0 pulses o_desc_err the next cycle. The descriptor is not accepted and r_next_bank is not toggled.
- Completion reporting: one report per cycle.
  - If both banks are in DONE, bank 0 reports first.
  - The other bank stays in DONE and reports the following cycle.
  - Each report pulses o_done_stb with o_done_bank, increments o_done_count, and sets o_int.
- o_int is cleared by i_int_clear. If a set and a clear occur in the same cycle, set wins.
- o_enable = i_run && (either bank in SETTLE or ACTIVE), registered.
- i_run low:
  - The datapath is paused.
  - Bank states and descriptor acceptance are unaffected.
  - An ACTIVE bank resumes when i_run returns.
- Abort, next cycle:
  - Every non-IDLE bank drives size to 0, pulses new_data (count becomes 0 with pointer 0), and goes to IDLE with no completion report.
  - r_next_bank is set to 0.
  - o_enable goes to 0.
  - o_done_count and o_int are unchanged.
- A descriptor strobe in the abort cycle is ignored.

## Timing
- Reset values: all outputs 0; both FSMs IDLE; r_next_bank = 0.
  - o_desc_rdy goes high in the first cycle after reset release.
- Accept at edge T:
  - base, size and new_data are visible in cycle T+1 (ARM).
  - SETTLE is cycle T+2.
  - ACTIVE starts at T+3; o_enable is high from T+3 if i_run.
- Count 0 sampled in ACTIVE at cycle C: DONE at C+1; o_done_stb at C+1.
  - Bank size returns to 0 and the bank returns to IDLE at C+2.
  - Earliest re-accept for that bank is at C+2.
- Datapath count is ignored in IDLE, ARM and SETTLE.
- o_done_count is 32 bits and wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-operation clears everything immediately, including any pending DONE reports.

## Test plan
- Reset -> all outputs 0.
  - Then push base 0x0, size 16 -> bank 0 gets size 16 and a new_data pulse.
  - Model counts 16 down to 0 -> o_done_stb with o_done_bank = 0, o_done_count = 1, o_int = 1.
- Push two descriptors back to back (0x0/8, 0x200000/8).
  - Bank 0 then bank 1 are armed; o_desc_rdy drops after the second push.
  - Third push is stalled until bank 0 completes, then lands in bank 0.
- Both counts reach 0 in the same cycle -> bank 0 reports first, bank 1 one cycle later; o_done_count increments by 2.
- Push size 0 -> o_desc_err pulse; no new_data pulse; r_next_bank unchanged.
  - Next valid push still goes to the expected bank.
- Abort while both banks are ACTIVE -> both sizes 0, both new_data pulse, o_enable = 0, no o_done_stb.
  - Next push goes to bank 0.
- i_int_clear and a completion in the same cycle -> o_int stays 1.
  - Toggling i_run low mid-transfer drops o_enable without losing bank state.
